// File: rtl/serial_adder_pkg.sv
// Shared constants and state encoding for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a requester and the serial adder.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/fa_bit.sv
// One-bit combinational full adder cell.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, carry recirculated.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_adder_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-2:0]   sum_sh;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;

  logic               s_bit;
  logic               c_bit;
  logic [WIDTH-1:0]   sum_nxt;

  fa_bit u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (s_bit),
    .co (c_bit)
  );

  // Only the upper WIDTH-1 partial bits are stored; the final sum is this
  // cycle's bit prepended to them.
  assign sum_nxt = {s_bit, sum_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_sh <= sum_nxt[WIDTH-1:1];
          carry  <= c_bit;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          if (cnt == LAST) begin
            sum_r  <= sum_nxt;
            cout_r <= c_bit;
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and streaming checks for serial_adder at WIDTH=8.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One operation: start pulse, optional ignored start with other operands
  // in RUN cycle `poke`, then latency/result/single-pulse checks.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic [W-1:0] exp_sum, input logic exp_cout,
                        input int poke);
    int nb;
    bit seen;
    int extra;
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = cin;
    @(negedge clk);
    bus.start = 1'b0; bus.a = ~a; bus.b = ~b; bus.cin = ~cin;
    check({tag, "_busy_first"}, 64'(bus.busy), 64'(1));
    nb = 1; seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (poke != 0 && nb == poke) begin
        bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.busy && bus.done) check({tag, "_busy_and_done"}, 64'(1), 64'(0));
      if (bus.done) begin
        seen = 1;
        break;
      end
      if (bus.busy) nb++;
      else check({tag, "_sum_held"}, 64'(bus.sum), 64'(bus.sum ^ 8'hFF)); // idle before done is an error
    end
    bus.start = 1'b0;
    check({tag, "_done_seen"}, 64'(seen), 64'(1));
    check({tag, "_busy_cycles"}, 64'(nb), 64'(W));
    check({tag, "_sum"}, 64'(bus.sum), 64'(exp_sum));
    check({tag, "_cout"}, 64'(bus.cout), 64'(exp_cout));
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      extra += int'(bus.done) + int'(bus.busy);
    end
    check({tag, "_no_extra_activity"}, 64'(extra), 64'(0));
    check({tag, "_sum_after"}, 64'(bus.sum), 64'(exp_sum));
  endtask

  initial begin
    logic [W:0] exp_q[$];
    logic [W:0] e;
    logic [W:0] got;
    int         n_done;
    int         cyc;
    int         last_done;
    int         dones;
    bit         prev_busy;

    checks = 0; errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1;

    // Reset held with start asserted: nothing may leave IDLE
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_busy", 64'(bus.busy), 64'(0));
      check("rst_done", 64'(bus.done), 64'(0));
      check("rst_sum",  64'(bus.sum),  64'(0));
      check("rst_cout", 64'(bus.cout), 64'(0));
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 64'(bus.busy), 64'(0));

    run_op("t2", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 0);
    run_op("t3a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
    run_op("t3b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0);
    run_op("t4", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 3);

    // Abort mid-RUN via async reset
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hF0; bus.b = 8'h0F; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_busy_run4", 64'(bus.busy), 64'(1));
    check("t5_sum_held", 64'(bus.sum), 64'(8'h46));
    #2 rst_n = 1'b0;
    #1;
    check("t5_abort_busy", 64'(bus.busy), 64'(0));
    check("t5_abort_done", 64'(bus.done), 64'(0));
    check("t5_abort_sum",  64'(bus.sum),  64'(0));
    check("t5_abort_cout", 64'(bus.cout), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      dones += int'(bus.done) + int'(bus.busy);
    end
    check("t5_no_done_after_abort", 64'(dones), 64'(0));
    run_op("t5b", 8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 0);

    // Start held high: back-to-back operations with fresh operands per accept
    bus.start = 1'b1;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
    prev_busy = 1'b0; n_done = 0; cyc = 0; last_done = -1;
    while (n_done < 1000 && cyc < 11000) begin
      @(negedge clk);
      cyc++;
      if (bus.busy && !prev_busy) begin
        e = (W+1)'(bus.a) + (W+1)'(bus.b) + (W+1)'(bus.cin);
        exp_q.push_back(e);
        bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
      end
      if (bus.done) begin
        got = {bus.cout, bus.sum};
        if (exp_q.size() == 0) check("t6_unexpected_done", 64'(1), 64'(0));
        else check("t6_result", 64'(got), 64'(exp_q.pop_front()));
        if (last_done >= 0) check("t6_period", 64'(cyc - last_done), 64'(W + 2));
        last_done = cyc;
        n_done++;
      end
      prev_busy = bus.busy;
    end
    bus.start = 1'b0;
    check("t6_ops", 64'(n_done), 64'(1000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
